// File: rtl/mcp3002_sampler_pkg.sv
// Shared MCP3002 constants, controller state encoding and timing helpers.
package mcp3002_sampler_pkg;

    localparam int SCLK_PER_CONV = 15;
    localparam int CMD_BITS      = 4;
    localparam int NULL_BIT_IDX  = 4;
    localparam int DATA_BITS     = 10;
    localparam int LAST_BIT_IDX  = SCLK_PER_CONV - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_CLK_HI = 3'd2,
        ST_CLK_LO = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic int calc_cyc(input int clk_freq, input int spi_freq);
        return clk_freq / spi_freq;
    endfunction

    function automatic int calc_half(input int clk_freq, input int spi_freq);
        return calc_cyc(clk_freq, spi_freq) / 2;
    endfunction

    function automatic int calc_period(input int clk_freq, input int fs);
        return clk_freq / fs;
    endfunction

    // Command word clocked out MSB-first: start, SGL, channel select, MSBF.
    function automatic logic cmd_bit(input logic [3:0] idx, input logic channel);
        logic b;
        if (idx >= 4'(CMD_BITS)) begin
            b = 1'b0;
        end else begin
            case (idx)
                4'd0:    b = 1'b1;
                4'd1:    b = 1'b1;
                4'd2:    b = channel;
                4'd3:    b = 1'b1;
                default: b = 1'b0;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/mcp3002_sampler_if.sv
// Pin-level and sample-side signals of the MCP3002 sampler; master = controller side.
interface mcp3002_sampler_if;
    import mcp3002_sampler_pkg::*;

    logic                 en;
    logic                 adc_clk;
    logic                 adc_din;
    logic                 adc_dout;
    logic                 adc_cs;
    logic [DATA_BITS-1:0] sample_data;
    logic                 sample_valid;
    logic                 overrun;

    modport master (
        input  en, adc_dout,
        output adc_clk, adc_din, adc_cs, sample_data, sample_valid, overrun
    );

    modport slave (
        output en, adc_dout,
        input  adc_clk, adc_din, adc_cs, sample_data, sample_valid, overrun
    );
endinterface

// File: rtl/mcp3002_sampler_sample_tick_gen.sv
// Free-running 0..PERIOD-1 counter producing a one-cycle tick on the last count.
module mcp3002_sampler_sample_tick_gen #(
    parameter int PERIOD = 500
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);
    localparam int             CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]  LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap at the period end.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Period counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/mcp3002_sampler.sv
// Periodic MCP3002 SPI sampling controller with registered pin and sample outputs.
// Build option: ADC_SIGNED_OUTPUT_EN converts the offset-binary code to two's complement.
module mcp3002_sampler
    import mcp3002_sampler_pkg::*;
#(
    parameter int CLK_FREQ          = 24_000_000,
    parameter int MCP3002_CLK_FREQ  = 800_000,
    parameter int ADC_SAMPLING_FREQ = 48_000,
    parameter int ADC_CHANNEL       = 0,
    parameter bit TIMING_CHECK_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mcp3002_sampler_if.master     bus
);
    localparam int CYC   = calc_cyc(CLK_FREQ, MCP3002_CLK_FREQ);
    localparam int H     = calc_half(CLK_FREQ, MCP3002_CLK_FREQ);
    localparam int P     = calc_period(CLK_FREQ, ADC_SAMPLING_FREQ);
    localparam int CNT_W = (H > 1) ? $clog2(H) : 1;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H - 1);
    localparam logic CH_BIT    = (ADC_CHANNEL != 0) ? 1'b1 : 1'b0;
    localparam bit   TIMING_OK = ((31 * H + 2) <= P) && (CYC >= 2) && ((CYC % 2) == 0);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           k_q, k_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 cs_q, cs_d;
    logic                 adc_clk_q, adc_clk_d;
    logic                 din_q, din_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic                 tick_s;

    mcp3002_sampler_sample_tick_gen #(.PERIOD(P)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick_s)
    );

    // State, sequencing and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            k_q       <= 4'd0;
            shift_q   <= '0;
            cs_q      <= 1'b1;
            adc_clk_q <= 1'b0;
            din_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            shift_q   <= shift_d;
            cs_q      <= cs_d;
            adc_clk_q <= adc_clk_d;
            din_q     <= din_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    // Next-state: half-period timing, bit index and capture of data bits k=5..14.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_s && bus.en) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == H_LAST) begin
                    state_d = ST_CLK_HI;
                    cnt_d   = '0;
                    k_d     = 4'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CLK_HI: begin
                if ((cnt_q == '0) && (k_q > 4'(NULL_BIT_IDX))) begin
                    shift_d = {shift_q[DATA_BITS-2:0], bus.adc_dout};
                end else begin
                    shift_d = shift_q;
                end
                if (cnt_q == H_LAST) begin
                    state_d = ST_CLK_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CLK_LO: begin
                if (cnt_q != H_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (k_q == 4'(LAST_BIT_IDX)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_CLK_HI;
                    cnt_d   = '0;
                    k_d     = k_q + 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs derived from the upcoming state; LO drives the next command bit early.
    always_comb begin
        cs_d      = 1'b1;
        adc_clk_d = 1'b0;
        din_d     = 1'b0;
        data_d    = data_q;
        valid_d   = 1'b0;
        case (state_d)
            ST_SETUP: begin
                cs_d  = 1'b0;
                din_d = cmd_bit(4'd0, CH_BIT);
            end
            ST_CLK_HI: begin
                cs_d      = 1'b0;
                adc_clk_d = 1'b1;
                din_d     = cmd_bit(k_d, CH_BIT);
            end
            ST_CLK_LO: begin
                cs_d  = 1'b0;
                din_d = cmd_bit(k_d + 4'd1, CH_BIT);
            end
            ST_DONE: begin
                valid_d = 1'b1;
`ifdef ADC_SIGNED_OUTPUT_EN
                data_d  = shift_d ^ {1'b1, {(DATA_BITS-1){1'b0}}};
`else
                data_d  = shift_d;
`endif
            end
            default: begin
                cs_d = 1'b1;
            end
        endcase
        if (tick_s && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end else begin
            ovr_d = ovr_q;
        end
    end

    if (TIMING_CHECK_EN) begin : g_timing_chk
        // Parameter sanity: conversion plus one idle cycle must fit inside a period.
        always_ff @(posedge clk) begin
            assert (TIMING_OK);
        end
    end

    assign bus.adc_cs       = cs_q;
    assign bus.adc_clk      = adc_clk_q;
    assign bus.adc_din      = din_q;
    assign bus.sample_data  = data_q;
    assign bus.sample_valid = valid_q;
    assign bus.overrun      = ovr_q;
endmodule
